// File: rtl/legendre_rhs_if.sv
// legendre_rhs_if: host start/result signals plus the shared modular arithmetic unit handshake
interface legendre_rhs_if #(parameter int N = 512);
  logic         start;
  logic [N-1:0] x_in;
  logic [N-1:0] a_in;
  logic         done;
  logic         is_square;
  logic         is_zero;
  logic [N-1:0] rhs;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [1:0]   op;
  logic [N-1:0] mul;
  logic         rst_mul;
  logic         done_mul;
  modport slave (
    input  start, x_in, a_in, mul, done_mul,
    output done, is_square, is_zero, rhs, A, B, op, rst_mul
  );
  modport master (
    output start, x_in, a_in, mul, done_mul,
    input  done, is_square, is_zero, rhs, A, B, op, rst_mul
  );
endinterface

// File: rtl/legendre_rhs.sv
// legendre_rhs: rhs = x^3 + A*x^2 + x and its constant-time Euler criterion rhs^((p-1)/2)
module legendre_rhs #(
  parameter int           N   = 512,
  parameter logic [N-1:0] P   = 512'h65b48e8f740f89bffc8ab0d15e3e4c4ab42d083aedc88c425afbfcc69322c9cda7aac6c567f35507516730cc1f0b4f25c2721bf457aca8351b81b90533c6c87b,
  // 2p < 2^N < 3p, so R mod p = 2^N - 2p
  parameter logic [N-1:0] FP1 = {N{1'b0}} - {P[N-2:0], 1'b0},
  parameter logic [N-1:0] E   = P >> 1
) (
  input logic          clk,
  input logic          rst,
  legendre_rhs_if.slave io
);
  localparam int IW = $clog2(N);
  typedef enum logic [3:0] {IDLE, ADD1, MUL1, ADD2, MUL2, SQR, MULC, SEL, CMP, DONE} state_t;
  state_t         state_q, state_d;
  logic [IW-1:0]  i_q, i_d;
  logic [N-1:0]   x_q, x_d, a_q, a_d, t_q, t_d, acc_q, acc_d, tmp_q, tmp_d, rhs_q, rhs_d;
  logic           done_q, done_d, sq_q, sq_d, zero_q, zero_d, rm_q, rm_d;
  logic [N-1:0]   opa, opb;
  logic [1:0]     opc;
  logic           arith, cap;
  always_comb begin
    arith   = state_q inside {ADD1, MUL1, ADD2, MUL2, SQR, MULC};
    cap     = arith & io.done_mul & ~rm_q;
    rm_d    = ~arith | cap;
    opa     = '0;
    opb     = '0;
    opc     = 2'b00;
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    a_d     = a_q;
    t_d     = t_q;
    acc_d   = acc_q;
    tmp_d   = tmp_q;
    rhs_d   = rhs_q;
    done_d  = done_q;
    sq_d    = sq_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE, DONE: if (io.start) begin
        x_d     = io.x_in;
        a_d     = io.a_in;
        done_d  = 1'b0;
        sq_d    = 1'b0;
        zero_d  = 1'b0;
        state_d = ADD1;
      end
      ADD1: begin
        opa = x_q;
        opb = a_q;
        opc = 2'b01;
        if (cap) begin
          t_d     = io.mul;
          state_d = MUL1;
        end
      end
      MUL1: begin
        opa = t_q;
        opb = x_q;
        if (cap) begin
          t_d     = io.mul;
          state_d = ADD2;
        end
      end
      ADD2: begin
        opa = t_q;
        opb = FP1;
        opc = 2'b01;
        if (cap) begin
          t_d     = io.mul;
          state_d = MUL2;
        end
      end
      MUL2: begin
        opa = t_q;
        opb = x_q;
        if (cap) begin
          rhs_d   = io.mul;
          acc_d   = FP1;
          i_d     = IW'(N - 1);
          state_d = SQR;
        end
      end
      SQR: begin
        opa = acc_q;
        opb = acc_q;
        if (cap) begin
          acc_d   = io.mul;
          state_d = MULC;
        end
      end
      // the multiply is always performed; only the select depends on the exponent bit
      MULC: begin
        opa = acc_q;
        opb = rhs_q;
        if (cap) begin
          tmp_d   = io.mul;
          state_d = SEL;
        end
      end
      SEL: begin
        acc_d   = E[i_q] ? tmp_q : acc_q;
        i_d     = (i_q == '0) ? i_q : i_q - IW'(1);
        state_d = (i_q == '0) ? CMP : SQR;
      end
      CMP: begin
        sq_d    = acc_q == FP1;
        zero_d  = rhs_q == '0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= IW'(N - 1);
      x_q     <= '0;
      a_q     <= '0;
      t_q     <= '0;
      acc_q   <= '0;
      tmp_q   <= '0;
      rhs_q   <= '0;
      done_q  <= 1'b0;
      sq_q    <= 1'b0;
      zero_q  <= 1'b0;
      rm_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      x_q     <= x_d;
      a_q     <= a_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
      tmp_q   <= tmp_d;
      rhs_q   <= rhs_d;
      done_q  <= done_d;
      sq_q    <= sq_d;
      zero_q  <= zero_d;
      rm_q    <= rm_d;
    end
  end
  assign io.A         = opa;
  assign io.B         = opb;
  assign io.op        = opc;
  assign io.rst_mul   = rm_q;
  assign io.done      = done_q;
  assign io.is_square = sq_q;
  assign io.is_zero   = zero_q;
  assign io.rhs       = rhs_q;
endmodule
